// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM states, word geometry, word-count rule.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LOAD,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // A count byte of this value means "fill the whole memory".
  localparam logic [7:0] N_ALL_WORDS = 8'd0;

  function automatic logic [8:0] word_count(
    input logic [7:0] n,
    input int         depth
  );
    return (n == N_ALL_WORDS) ? 9'(depth) : {1'b0, n};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: inserts bytes little-endian into a 32-bit word.
// Ports: clr/load control, din byte in; word out, word_full on 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] cnt;

  // High in the cycle the last lane is being filled.
  assign word_full = load && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      word[{cnt, 3'b000} +: 8] <= din;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a boot image into imem and gates CPU reset.
// Ports: start/in_* byte stream, cpu_pc in; imem_*, cpu_reset, busy, err out.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_DONE = S_CHECK;
`else
  localparam state_t S_DONE = S_RUN;
`endif

  state_t     state, state_n;
  logic [8:0] idx, n_words, n_req;
  logic       accept, full, last_word;
  logic       rdy_n, chk_n;

  assign accept    = in_valid && in_ready;
  assign n_req     = word_count(in_data, DEPTH);
  assign last_word = (idx + 9'd1) == n_words;
  assign imem_addr = (state == S_RUN) ? cpu_pc : ADDR_W'(idx);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (reset || state == S_COUNT)
      csum <= '0;
    else if (state == S_LOAD && accept)
      csum <= csum ^ in_data;
  end

  assign chk_n = (state_n == S_CHECK);
`else
  assign chk_n = 1'b0;
`endif

  byte_packer u_pack (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == S_COUNT),
    .load      ((state == S_LOAD) && accept),
    .din       (in_data),
    .word      (imem_wdata),
    .word_full (full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = S_COUNT;
      S_COUNT:
        if (accept)
          state_n = (n_req > 9'(DEPTH)) ? S_ERROR : S_LOAD;
      S_LOAD:
        if (full) state_n = S_WRITE;
      S_WRITE:
        state_n = last_word ? S_DONE : S_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:
        if (accept)
          state_n = (in_data == csum) ? S_RUN : S_ERROR;
`endif
      S_RUN, S_ERROR:
        if (start) state_n = S_COUNT;
      default:
        state_n = S_IDLE;
    endcase
  end

  assign rdy_n = (state_n == S_COUNT) || (state_n == S_LOAD) || chk_n;

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      n_words   <= '0;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == S_COUNT)
        idx <= '0;
      else if (state == S_WRITE)
        idx <= idx + 9'd1;
      if (state == S_COUNT && accept)
        n_words <= n_req;
      in_ready  <= rdy_n;
      imem_we   <= (state_n == S_WRITE);
      cpu_reset <= (state_n != S_RUN);
      busy      <= rdy_n || (state_n == S_WRITE);
      err       <= (state_n == S_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus,
// popped by a write monitor; control outputs checked at fixed points.
module tb_imem_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  logic              clk = 0;
  logic              reset = 1;
  logic              start = 0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 0;
  logic              in_ready;
  logic [ADDR_W-1:0] cpu_pc = '0;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cpu_pc     (cpu_pc),
    .imem_addr  (imem_addr),
    .imem_we    (imem_we),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] img[DEPTH];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          t0;
  logic        prev_we = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      chk("we_one_cycle", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0)
        chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e.addr);
        chk("wr_data", imem_wdata, e.data);
      end
    end
    prev_we = imem_we;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 0;
  endtask

  task automatic load(input int nbyte, input int nw, input bit gap,
                      input bit bad);
    logic [7:0]  x = '0;
    logic [31:0] w;
    send_byte(8'(nbyte));
    for (int i = 0; i < nw; i++) begin
      w = img[i];
      exp_q.push_back('{addr: 32'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
        if (gap) tick();
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad ? (x ^ 8'h01) : x);
`else
    if (bad) chk("bad_csum_unsupported", 32'd0, 32'd1);
`endif
  endtask

  task automatic wait_run;
    int t = 0;
    while (cpu_reset && t < 100) begin
      tick();
      t++;
    end
    chk("run_reached", 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;

    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // Two-word load, back-to-back stream.
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    pulse_start();
    t0 = cyc;
    chk("count_busy", 32'(busy), 32'd1);
    chk("count_ready", 32'(in_ready), 32'd1);
    load(2, 2, 0, 0);
    wait_run();
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("load_cycles", 32'(cyc - t0), 32'd12);
`else
    chk("load_cycles", 32'(cyc - t0), 32'd11);
`endif
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_ready", 32'(in_ready), 32'd0);
    cpu_pc = 32'd5;
    #1;
    chk("run_addr_pc", imem_addr, 32'd5);

    // Restart from RUN, full-depth load via N=0.
    pulse_start();
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++)
      img[i] = 32'h30201000 + 32'(i) * 32'h01010101;
    load(0, DEPTH, 0, 0);
    wait_run();

    // Oversize image.
    pulse_start();
    send_byte(8'd9);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd0);
    tick();
    chk("ovf_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);

    // One word with gaps in in_valid.
    img[0] = 32'hD4C3B2A1;
    load(1, 1, 1, 0);
    wait_run();

    // Reset mid-word.
    pulse_start();
    send_byte(8'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    chk("mid_rst_no_write", 32'(exp_q.size()), 32'd0);
    tick();
    chk("idle_ready", 32'(in_ready), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0] = 32'h08040201;
    pulse_start();
    load(1, 1, 0, 0);
    wait_run();
    pulse_start();
    load(1, 1, 0, 1);
    chk("csum_err", 32'(err), 32'd1);
    chk("csum_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
